// File: rtl/siganfu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : siganfu_pkg
// Purpose  : Shared types and default constants for SIGANFU target acquisition.
//            Provides the acquisition FSM state encoding and the default
//            lock / loss / timeout / hold cycle counts.
// Revision : 1.0 - initial release
// ============================================================================
package siganfu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_SEARCH   = 3'b001,
    ST_IFF_WAIT = 3'b010,
    ST_ENGAGE   = 3'b011,
    ST_ABORT    = 3'b100
  } acq_state_t;

  localparam int unsigned c_LOCK_HITS   = 4;
  localparam int unsigned c_LOSS_MISSES = 3;
  localparam int unsigned c_IFF_TIMEOUT = 20;
  localparam int unsigned c_ABORT_HOLD  = 10;

endpackage : siganfu_pkg
`default_nettype wire

// File: rtl/siganfu_consec_counter.sv
`default_nettype none
// ============================================================================
// Module   : siganfu_consec_counter
// Purpose  : Saturating counter of consecutive events with a threshold flag.
//            thresh_o is high in the cycle whose increment brings the count
//            to MAX, so the caller can act on the same edge.
// Ports    : clk_i     - clock (rising edge)
//            rst_i     - synchronous active-high reset
//            clear_i   - synchronous clear (highest priority after reset)
//            inc_i     - event to count this cycle
//            restart_i - opposite event; breaks the run and zeroes the count
//            thresh_o  - this cycle's increment reaches MAX
// Revision : 1.0 - initial release
// ============================================================================
module siganfu_consec_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic inc_i,
  input  logic restart_i,
  output logic thresh_o
);

  localparam int unsigned CNT_W = $clog2(MAX + 1);
  localparam logic [CNT_W-1:0] c_MAX  = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Independent of clear_i so the caller may feed thresh_o back into clear_i.
  assign thresh_o = inc_i & ~restart_i & (cnt_q >= c_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || restart_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != c_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : siganfu_consec_counter
`default_nettype wire

// File: rtl/siganfu_target_acquisition.sv
`default_nettype none
// ============================================================================
// Module   : siganfu_target_acquisition
// Purpose  : Lock / identify / engage sequencer feeding the gun fire control.
//            Counts radar hits to lock, asks the IFF transponder, engages only
//            on a positive enemy answer, and drops lock on consecutive misses.
// Ports    : sysclk, reboot (sync active-high reset), system_arm,
//            radar_valid/radar_hit, iff_req, iff_resp_valid/iff_friend,
//            operator_fire, target_locked, is_enemy, fire_command, acq_state.
//            All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module siganfu_target_acquisition
  import siganfu_pkg::*;
#(
  parameter int unsigned LOCK_HITS   = c_LOCK_HITS,
  parameter int unsigned LOSS_MISSES = c_LOSS_MISSES,
  parameter int unsigned IFF_TIMEOUT = c_IFF_TIMEOUT,
  parameter int unsigned ABORT_HOLD  = c_ABORT_HOLD
) (
  input  logic       sysclk,
  input  logic       reboot,
  input  logic       system_arm,
  input  logic       radar_valid,
  input  logic       radar_hit,
  output logic       iff_req,
  input  logic       iff_resp_valid,
  input  logic       iff_friend,
  input  logic       operator_fire,
  output logic       target_locked,
  output logic       is_enemy,
  output logic       fire_command,
  output logic [2:0] acq_state
);

  // One timer serves both the IFF answer wait and the abort hold.
  localparam int unsigned TMR_MAX = (IFF_TIMEOUT > ABORT_HOLD) ? IFF_TIMEOUT : ABORT_HOLD;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] c_TMR_MAX   = TMR_W'(TMR_MAX);
  localparam logic [TMR_W-1:0] c_IFF_LAST  = TMR_W'(IFF_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] c_HOLD_LAST = TMR_W'(ABORT_HOLD - 1);

  acq_state_t       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d, tmr_inc;
  logic             locked_q, locked_d;
  logic             enemy_q, enemy_d;
  logic             fire_q, fire_d;
  logic             iff_req_q, iff_req_d;

  logic radar_h, radar_m;
  logic in_track;
  logic hit_lock, miss_loss;

  assign radar_h  = radar_valid & radar_hit;
  assign radar_m  = radar_valid & ~radar_hit;
  assign in_track = (state_q == ST_IFF_WAIT) || (state_q == ST_ENGAGE);
  assign tmr_inc  = (tmr_q == c_TMR_MAX) ? tmr_q : tmr_q + 1'b1;

  // Hit run only matters in SEARCH; cleared on lock so a later SEARCH starts fresh.
  siganfu_consec_counter #(.MAX(LOCK_HITS)) u_hit_cnt (
    .clk_i     (sysclk),
    .rst_i     (reboot),
    .clear_i   (~system_arm | (state_q != ST_SEARCH) | hit_lock),
    .inc_i     (radar_h),
    .restart_i (radar_m),
    .thresh_o  (hit_lock)
  );

  // Miss run spans IFF_WAIT and ENGAGE continuously.
  siganfu_consec_counter #(.MAX(LOSS_MISSES)) u_miss_cnt (
    .clk_i     (sysclk),
    .rst_i     (reboot),
    .clear_i   (~system_arm | ~in_track | miss_loss),
    .inc_i     (radar_m),
    .restart_i (radar_h),
    .thresh_o  (miss_loss)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = '0;
    case (state_q)
      ST_IDLE:   state_d = ST_SEARCH;
      ST_SEARCH: if (hit_lock) state_d = ST_IFF_WAIT;
      ST_IFF_WAIT: begin
        tmr_d = tmr_inc;
        // Track loss beats an answer; an answer beats the timeout.
        if (miss_loss) begin
          state_d = ST_SEARCH;
          tmr_d   = '0;
        end else if (iff_resp_valid) begin
          state_d = iff_friend ? ST_ABORT : ST_ENGAGE;
          tmr_d   = '0;
        end else if (tmr_q >= c_IFF_LAST) begin
          state_d = ST_ABORT;  // no answer: fail safe, treat as friend
          tmr_d   = '0;
        end
      end
      ST_ENGAGE: if (miss_loss) state_d = ST_SEARCH;
      ST_ABORT: begin
        tmr_d = tmr_inc;
        if (tmr_q >= c_HOLD_LAST) begin
          state_d = ST_SEARCH;
          tmr_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!system_arm) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
    end
  end

  // Level outputs follow the next state so they change on the same edge as it.
  always_comb begin
    locked_d  = (state_d == ST_IFF_WAIT) || (state_d == ST_ENGAGE);
    enemy_d   = (state_d == ST_ENGAGE);
    iff_req_d = (state_d == ST_IFF_WAIT);
    fire_d    = operator_fire & (state_d == ST_ENGAGE);
  end

  always_ff @(posedge sysclk) begin
    if (reboot) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      locked_q  <= 1'b0;
      enemy_q   <= 1'b0;
      fire_q    <= 1'b0;
      iff_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      locked_q  <= locked_d;
      enemy_q   <= enemy_d;
      fire_q    <= fire_d;
      iff_req_q <= iff_req_d;
    end
  end

  assign target_locked = locked_q;
  assign is_enemy      = enemy_q;
  assign fire_command  = fire_q;
  assign iff_req       = iff_req_q;
  assign acq_state     = state_q;

endmodule : siganfu_target_acquisition
`default_nettype wire

// File: tb/tb_siganfu_target_acquisition.sv
`default_nettype none
// ============================================================================
// Module   : tb_siganfu_target_acquisition
// Purpose  : Self-checking bench for siganfu_target_acquisition: directed
//            scenarios followed by randomized traffic, all compared every
//            cycle against a behavioural model of the acquisition rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_siganfu_target_acquisition;

  localparam int LOCK    = 4;
  localparam int LOSS    = 3;
  localparam int TIMEOUT = 20;
  localparam int HOLD    = 10;

  logic       sysclk = 1'b0;
  logic       reboot = 1'b0;
  logic       system_arm = 1'b0;
  logic       radar_valid = 1'b0;
  logic       radar_hit = 1'b0;
  logic       iff_resp_valid = 1'b0;
  logic       iff_friend = 1'b0;
  logic       operator_fire = 1'b0;
  logic       iff_req;
  logic       target_locked;
  logic       is_enemy;
  logic       fire_command;
  logic [2:0] acq_state;

  int n_vec = 0;
  int n_mis = 0;

  // Behavioural model: mode 0 idle, 1 search, 2 waiting for IFF, 3 engage, 4 abort
  int m_mode = 0;
  int m_hits = 0;
  int m_miss = 0;
  int m_wait = 0;
  bit m_fire = 1'b0;

  logic fire_lvl = 1'b0;

  always #5 sysclk = ~sysclk;

  siganfu_target_acquisition dut (
    .sysclk         (sysclk),
    .reboot         (reboot),
    .system_arm     (system_arm),
    .radar_valid    (radar_valid),
    .radar_hit      (radar_hit),
    .iff_req        (iff_req),
    .iff_resp_valid (iff_resp_valid),
    .iff_friend     (iff_friend),
    .operator_fire  (operator_fire),
    .target_locked  (target_locked),
    .is_enemy       (is_enemy),
    .fire_command   (fire_command),
    .acq_state      (acq_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs present at this edge.
  task automatic model_step();
    int nmode = m_mode;
    int nh = 0;
    int nm = 0;
    int nw = 0;
    if (reboot || !system_arm) begin
      nmode = 0;
    end else begin
      case (m_mode)
        0: nmode = 1;
        1: begin
          nh = m_hits;
          if (radar_valid) nh = radar_hit ? m_hits + 1 : 0;
          if (nh >= LOCK) begin nmode = 2; nh = 0; end
        end
        2, 3: begin
          nm = m_miss;
          if (radar_valid) nm = radar_hit ? 0 : m_miss + 1;
          if (m_mode == 2) nw = m_wait + 1;
          if (nm >= LOSS) begin
            nmode = 1; nm = 0; nw = 0;
          end else if (m_mode == 2 && iff_resp_valid) begin
            nmode = iff_friend ? 4 : 3; nw = 0;
          end else if (m_mode == 2 && nw >= TIMEOUT) begin
            nmode = 4; nw = 0;
          end
          if (nmode != 2 && nmode != 3) nm = 0;
        end
        4: begin
          nw = m_wait + 1;
          if (nw >= HOLD) begin nmode = 1; nw = 0; end
        end
        default: nmode = 0;
      endcase
    end
    m_fire = !reboot && system_arm && operator_fire && (nmode == 3);
    m_mode = nmode; m_hits = nh; m_miss = nm; m_wait = nw;
  endtask

  task automatic tick();
    @(posedge sysclk);
    model_step();
    #1;
    check_eq("acq_state", {29'd0, acq_state}, m_mode);
    check_eq("target_locked", {31'd0, target_locked}, (m_mode == 2 || m_mode == 3) ? 1 : 0);
    check_eq("is_enemy", {31'd0, is_enemy}, (m_mode == 3) ? 1 : 0);
    check_eq("iff_req", {31'd0, iff_req}, (m_mode == 2) ? 1 : 0);
    check_eq("fire_command", {31'd0, fire_command}, {31'd0, m_fire});
  endtask

  task automatic drive(input logic arm, input logic rb, input logic v, input logic h,
                       input logic r, input logic f, input logic fire);
    system_arm = arm; reboot = rb; radar_valid = v; radar_hit = h;
    iff_resp_valid = r; iff_friend = f; operator_fire = fire;
    tick();
  endtask

  task automatic st(input logic v, input logic h, input logic r, input logic f);
    drive(1'b1, 1'b0, v, h, r, f, fire_lvl);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) st(0, 0, 0, 0);
  endtask

  task automatic lock4();
    for (int k = 0; k < LOCK; k++) st(1, 1, 0, 0);
  endtask

  int hitpct = 80;

  initial begin
    // reset and arm
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 1, 0, 1);
    check_eq("rst_state", {29'd0, acq_state}, 32'd0);
    check_eq("rst_locked", {31'd0, target_locked}, 32'd0);
    st(0, 0, 0, 0);
    check_eq("armed_search", {29'd0, acq_state}, 32'd1);

    // three hits then a miss: no lock
    st(1, 1, 0, 0); st(0, 0, 0, 0); st(1, 1, 0, 0); st(0, 0, 0, 0);
    st(1, 1, 0, 0); st(1, 0, 0, 0);
    check_eq("miss_no_lock", {29'd0, acq_state}, 32'd1);
    // four spaced hits lock
    st(1, 1, 0, 0); st(0, 0, 0, 0); st(1, 1, 0, 0); st(0, 0, 0, 0);
    st(1, 1, 0, 0); st(0, 0, 0, 0); st(1, 1, 0, 0);
    check_eq("lock_state", {29'd0, acq_state}, 32'd2);
    check_eq("lock_iff_req", {31'd0, iff_req}, 32'd1);

    // enemy answer, then trigger
    st(0, 0, 1, 0);
    check_eq("engage_state", {29'd0, acq_state}, 32'd3);
    check_eq("engage_enemy", {31'd0, is_enemy}, 32'd1);
    fire_lvl = 1'b1; st(0, 0, 0, 0);
    check_eq("fire_rise", {31'd0, fire_command}, 32'd1);
    fire_lvl = 1'b0; st(0, 0, 0, 0);
    check_eq("fire_fall", {31'd0, fire_command}, 32'd0);

    // hit,miss,miss,hit,miss keeps lock; two more misses break it
    fire_lvl = 1'b1;
    st(1, 1, 0, 0); st(1, 0, 0, 0); st(1, 0, 0, 0); st(1, 1, 0, 0); st(1, 0, 0, 0);
    check_eq("no_break", {29'd0, acq_state}, 32'd3);
    st(1, 0, 0, 0); st(1, 0, 0, 0);
    check_eq("loss_state", {29'd0, acq_state}, 32'd1);
    check_eq("loss_fire", {31'd0, fire_command}, 32'd0);
    fire_lvl = 1'b0;

    // IFF timeout then abort hold
    lock4(); idle(TIMEOUT);
    check_eq("timeout_abort", {29'd0, acq_state}, 32'd4);
    check_eq("timeout_unlock", {31'd0, target_locked}, 32'd0);
    idle(HOLD);
    check_eq("abort_to_search", {29'd0, acq_state}, 32'd1);

    // enemy answer together with third miss: loss wins
    lock4(); st(1, 0, 0, 0); st(1, 0, 0, 0); st(1, 0, 1, 0);
    check_eq("loss_vs_answer", {29'd0, acq_state}, 32'd1);
    check_eq("loss_vs_answer_enemy", {31'd0, is_enemy}, 32'd0);

    // answer in the timeout cycle: answer wins
    lock4(); idle(TIMEOUT - 1); st(0, 0, 1, 0);
    check_eq("answer_vs_timeout", {29'd0, acq_state}, 32'd3);

    // reboot mid-engage
    fire_lvl = 1'b1; st(0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 1);
    check_eq("reboot_state", {29'd0, acq_state}, 32'd0);
    check_eq("reboot_fire", {31'd0, fire_command}, 32'd0);
    fire_lvl = 1'b0;

    // disarm mid-IFF_WAIT
    st(0, 0, 0, 0); lock4();
    drive(0, 0, 0, 0, 0, 0, 0);
    check_eq("disarm_state", {29'd0, acq_state}, 32'd0);
    check_eq("disarm_iff_req", {31'd0, iff_req}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) hitpct = (i % 750 == 0) ? 90 : ((i % 500 == 0) ? 30 : 65);
      if ($urandom_range(3) == 0) fire_lvl = ~fire_lvl;
      drive(($urandom_range(149) != 0), ($urandom_range(399) == 0),
            $urandom_range(1) == 1, ($urandom_range(99) < hitpct),
            ($urandom_range(24) == 0), $urandom_range(1) == 1, fire_lvl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule : tb_siganfu_target_acquisition
`default_nettype wire
